// File: rtl/ahb_gpio_irq_par_pkg.sv
// rtl/ahb_gpio_irq_par_pkg.sv - shared constants and types for the AHB GPIO slave
// Purpose: register offsets, PCTRL bit positions and the registered address-phase record.
// Ports: none (package).
package ahb_gpio_pkg;

  localparam logic [7:0] OFF_DATA  = 8'h00;
  localparam logic [7:0] OFF_DIR   = 8'h04;
  localparam logic [7:0] OFF_PCTRL = 8'h08;
  localparam logic [7:0] OFF_IE    = 8'h0C;
  localparam logic [7:0] OFF_ITYPE = 8'h10;
  localparam logic [7:0] OFF_ISTAT = 8'h14;

  localparam int PCTRL_ODD         = 0;
  localparam int PCTRL_CHK_EN      = 1;
  localparam int PCTRL_PERR_IRQ_EN = 2;
  localparam int PCTRL_W           = 3;

  // Address-phase attributes carried into the data phase.
  typedef struct packed {
    logic [7:0] addr;
    logic       write;
    logic       sel;
    logic       trans;
  } ahb_aphase_t;

endpackage

// File: rtl/ahb_gpio_irq_par_if.sv
// rtl/ahb_gpio_irq_par_if.sv - AHB-Lite slave bus bundle
// Purpose: groups the AHB-Lite request/response signals of one slave port.
// Ports: none; signals HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY (master to slave),
//        HREADYOUT, HRESP, HRDATA (slave to master).
interface ahb_gpio_irq_par_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_gpio_irq_par_sync_edge.sv
// rtl/ahb_gpio_irq_par_sync_edge.sv - pad input synchroniser with edge detection
// Purpose: SYNC_STAGES-deep synchroniser followed by a previous-value flop.
// Ports: HCLK, HRESETn (async, active-low); din_i[W] raw pads;
//        sync_o[W] synchronised value; rise_o/fall_o[W] single-cycle edge strobes.
module gpio_sync_edge #(
  parameter int W           = 17,
  parameter int SYNC_STAGES = 2
) (
  input  logic         HCLK,
  input  logic         HRESETn,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] sync_o,
  output logic [W-1:0] rise_o,
  output logic [W-1:0] fall_o
);

  logic [W-1:0] sync_q [SYNC_STAGES];
  logic [W-1:0] prev_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= din_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];
  assign rise_o = sync_o & ~prev_q;
  assign fall_o = ~sync_o & prev_q;

endmodule

// File: rtl/ahb_gpio_irq_par.sv
// rtl/ahb_gpio_irq_par.sv - AHB-Lite GPIO slave with parity and edge interrupts
// Purpose: zero-wait-state GPIO with per-bit direction, generated output parity,
//          checked input parity (sticky error), per-bit edge interrupts with W1C status.
// Ports: HCLK, HRESETn (async, active-low); ahb (AHB-Lite slave bundle);
//        GPIOIN[GPIO_W:0] pads (MSB = received parity); GPIOOUT[GPIO_W:0] pads (MSB = parity);
//        GPIOEN[GPIO_W-1:0] output enables; GPIOIRQ level interrupt.
module ahb_gpio_irq_par
  import ahb_gpio_pkg::*;
#(
  parameter int GPIO_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  ahb_gpio_irq_par_if.slave ahb,
  input  logic [GPIO_W:0]   GPIOIN,
  output logic [GPIO_W:0]   GPIOOUT,
  output logic [GPIO_W-1:0] GPIOEN,
  output logic              GPIOIRQ
);

  ahb_aphase_t aph_q, aph_d;

  logic [GPIO_W-1:0]  dout_q, dout_d, dir_q, dir_d, ie_q, ie_d, itype_q, itype_d;
  logic [PCTRL_W-1:0] pctrl_q, pctrl_d;
  logic [GPIO_W:0]    istat_q, istat_d, istat_clr;
  logic               par_q, par_d, irq_q, irq_d;

  logic [GPIO_W:0]    sync_in, rise, fall;
  logic [GPIO_W-1:0]  evt;
  logic               perr, wr_en, rd_act;
  logic [31:0]        rdata;
  logic               unused_ok;

  gpio_sync_edge #(.W(GPIO_W+1), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .din_i   (GPIOIN),
    .sync_o  (sync_in),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  // The write commits when our (always-ready) data phase completes on the bus.
  assign wr_en  = aph_q.sel & aph_q.trans & aph_q.write & ahb.HREADY;
  assign rd_act = aph_q.sel & aph_q.trans & ~aph_q.write;

  assign evt  = (itype_q & fall[GPIO_W-1:0]) | (~itype_q & rise[GPIO_W-1:0]);
  // Parity is only meaningful when every pin, including the parity pin, is an input.
  assign perr = pctrl_q[PCTRL_CHK_EN] & (dir_q == '0) & (^sync_in ^ pctrl_q[PCTRL_ODD]);

  always_comb begin
    aph_d     = aph_q;
    dout_d    = dout_q;
    dir_d     = dir_q;
    pctrl_d   = pctrl_q;
    ie_d      = ie_q;
    itype_d   = itype_q;
    istat_clr = '0;
    if (ahb.HREADY) begin
      aph_d.addr  = ahb.HADDR[7:0];
      aph_d.write = ahb.HWRITE;
      aph_d.sel   = ahb.HSEL;
      aph_d.trans = ahb.HTRANS[1];
    end
    if (wr_en) begin
      case (aph_q.addr)
        OFF_DATA:  dout_d    = ahb.HWDATA[GPIO_W-1:0];
        OFF_DIR:   dir_d     = ahb.HWDATA[GPIO_W-1:0];
        OFF_PCTRL: pctrl_d   = ahb.HWDATA[PCTRL_W-1:0];
        OFF_IE:    ie_d      = ahb.HWDATA[GPIO_W-1:0];
        OFF_ITYPE: itype_d   = ahb.HWDATA[GPIO_W-1:0];
        OFF_ISTAT: istat_clr = ahb.HWDATA[GPIO_W:0];
        default:   ;
      endcase
    end
    // Set after clear so a coincident event keeps its status bit.
    istat_d = (istat_q & ~istat_clr) | {perr, evt};
    // Parity follows the new dout but the current odd bit.
    par_d   = ^dout_d ^ pctrl_q[PCTRL_ODD];
    irq_d   = (|(istat_q[GPIO_W-1:0] & ie_q)) | (istat_q[GPIO_W] & pctrl_q[PCTRL_PERR_IRQ_EN]);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      aph_q   <= '0;
      dout_q  <= '0;
      dir_q   <= '0;
      pctrl_q <= '0;
      ie_q    <= '0;
      itype_q <= '0;
      istat_q <= '0;
      par_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      aph_q   <= aph_d;
      dout_q  <= dout_d;
      dir_q   <= dir_d;
      pctrl_q <= pctrl_d;
      ie_q    <= ie_d;
      itype_q <= itype_d;
      istat_q <= istat_d;
      par_q   <= par_d;
      irq_q   <= irq_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (rd_act) begin
      case (aph_q.addr)
        OFF_DATA:  rdata = 32'((dir_q & dout_q) | (~dir_q & sync_in[GPIO_W-1:0]));
        OFF_DIR:   rdata = 32'(dir_q);
        OFF_PCTRL: rdata = 32'(pctrl_q);
        OFF_IE:    rdata = 32'(ie_q);
        OFF_ITYPE: rdata = 32'(itype_q);
        OFF_ISTAT: rdata = 32'(istat_q);
        default:   rdata = '0;
      endcase
    end
  end

  assign ahb.HRDATA    = rdata;
  assign ahb.HREADYOUT = 1'b1;
  assign ahb.HRESP     = 1'b0;
  assign GPIOOUT       = {par_q, dout_q};
  assign GPIOEN        = dir_q;
  assign GPIOIRQ       = irq_q;

  assign unused_ok = ^{ahb.HADDR[31:8], ahb.HTRANS[0], ahb.HWDATA, rise[GPIO_W], fall[GPIO_W]};

endmodule

// File: tb/tb_ahb_gpio_irq_par.sv
// tb/tb_ahb_gpio_irq_par.sv - self-checking bench for ahb_gpio_irq_par
module tb_ahb_gpio_irq_par;
  import ahb_gpio_pkg::*;

  localparam int GW = 16;
  localparam int SS = 2;

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic [GW:0]   GPIOIN = '0;
  logic [GW:0]   GPIOOUT;
  logic [GW-1:0] GPIOEN;
  logic          GPIOIRQ;

  int n_chk = 0;
  int n_fail = 0;

  ahb_gpio_irq_par_if bus ();

  ahb_gpio_irq_par #(.GPIO_W(GW), .SYNC_STAGES(SS)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .ahb     (bus.slave),
    .GPIOIN  (GPIOIN),
    .GPIOOUT (GPIOOUT),
    .GPIOEN  (GPIOEN),
    .GPIOIRQ (GPIOIRQ)
  );

  always #5 HCLK = ~HCLK;

  typedef struct packed {
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [7:0]  raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_idle();
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0; bus.HADDR = '0;
  endtask

  // Called and returning at posedge+1; the write has committed on return.
  task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1; bus.HADDR = a;
    @(posedge HCLK); #1;
    bus_idle();
    bus.HWDATA = d;
    @(posedge HCLK); #1;
  endtask

  task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b0; bus.HADDR = a;
    @(posedge HCLK); #1;
    bus_idle();
    d = bus.HRDATA;
    @(posedge HCLK); #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;

    tbl[0] = '{32'h04,   32'hFFFF_FFFF, OFF_DIR,   32'h0000_FFFF};
    tbl[1] = '{32'h0C,   32'h0001_2345, OFF_IE,    32'h0000_2345};
    tbl[2] = '{32'h10,   32'hFFFF_0F0F, OFF_ITYPE, 32'h0000_0F0F};
    tbl[3] = '{32'h08,   32'hFFFF_FFF8, OFF_PCTRL, 32'h0000_0000};
    tbl[4] = '{32'h08,   32'h0000_0005, OFF_PCTRL, 32'h0000_0005};
    tbl[5] = '{32'h00,   32'hFFFF_0003, OFF_DATA,  32'h0000_0003};
    tbl[6] = '{32'h1104, 32'h0000_00AA, OFF_DIR,   32'h0000_00AA};
    tbl[7] = '{32'h18,   32'hFFFF_FFFF, 8'h18,     32'h0000_0000};
    tbl[8] = '{32'h14,   32'h0001_FFFF, OFF_ISTAT, 32'h0000_0000};
    tbl[9] = '{32'h00,   32'h0000_FFFF, OFF_DATA,  32'h0000_00AA};

    bus_idle();
    bus.HREADY = 1'b1;
    bus.HWDATA = '0;
    cycles(3);

    // Reset state
    check("rst_gpioout", 32'(GPIOOUT), 32'h0);
    check("rst_gpioen",  32'(GPIOEN),  32'h0);
    check("rst_irq",     32'(GPIOIRQ), 32'h0);
    check("rst_hrdata",  bus.HRDATA,   32'h0);
    HRESETn = 1'b1;
    cycles(2);
    check("hreadyout",   32'(bus.HREADYOUT), 32'h1);
    check("hresp",       32'(bus.HRESP),     32'h0);

    // Register write/readback table
    for (int i = 0; i < 10; i++) begin
      ahb_write(tbl[i].waddr, tbl[i].wdata);
      ahb_read(32'(tbl[i].raddr), rd);
      check($sformatf("tbl%0d", i), rd, tbl[i].exp);
    end
    ahb_write(32'(OFF_IE), 32'h0);
    ahb_write(32'(OFF_ITYPE), 32'h0);
    ahb_write(32'(OFF_PCTRL), 32'h0);
    ahb_write(32'(OFF_DATA), 32'h0);

    // 1: output parity
    ahb_write(32'(OFF_DIR), 32'hFFFF);
    ahb_write(32'(OFF_DATA), 32'h0003);
    check("t1_out_even", 32'(GPIOOUT), 32'h0_0003);
    check("t1_en", 32'(GPIOEN), 32'hFFFF);
    ahb_write(32'(OFF_PCTRL), 32'h1);
    check("t1_odd_same", 32'(GPIOOUT), 32'h0_0003);
    cycles(1);
    check("t1_odd_next", 32'(GPIOOUT), 32'h1_0003);
    ahb_write(32'(OFF_PCTRL), 32'h0);

    // 2: input synchroniser latency and DATA read mux
    ahb_write(32'(OFF_DIR), 32'h0);
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b0; bus.HADDR = 32'(OFF_DATA);
    cycles(1);
    GPIOIN = 17'h0_A5A5;
    for (int k = 1; k <= SS; k++) begin
      cycles(1);
      check($sformatf("t2_lat%0d", k), bus.HRDATA, (k < SS) ? 32'h0 : 32'hA5A5);
    end
    bus_idle();
    cycles(1);
    ahb_write(32'(OFF_DIR), 32'h00FF);
    ahb_write(32'(OFF_DATA), 32'h1234);
    ahb_read(32'(OFF_DATA), rd);
    check("t2_mix", rd, 32'hA534);

    // 3: edge interrupts
    GPIOIN = '0;
    cycles(SS + 2);
    ahb_write(32'(OFF_ISTAT), 32'h1FFFF);
    ahb_write(32'(OFF_IE), 32'h1);
    ahb_write(32'(OFF_ITYPE), 32'h0);
    GPIOIN = 17'h1;
    cycles(SS + 3);
    ahb_read(32'(OFF_ISTAT), rd);
    check("t3_istat_rise", rd, 32'h1);
    check("t3_irq_on", 32'(GPIOIRQ), 32'h1);
    ahb_write(32'(OFF_ISTAT), 32'h1);
    cycles(2);
    check("t3_irq_off", 32'(GPIOIRQ), 32'h0);
    GPIOIN = '0;
    cycles(SS + 2);
    ahb_write(32'(OFF_ITYPE), 32'h1);
    GPIOIN = 17'h1;
    cycles(SS + 3);
    ahb_read(32'(OFF_ISTAT), rd);
    check("t3_fall_ignores_rise", rd, 32'h0);
    check("t3_irq_still_off", 32'(GPIOIRQ), 32'h0);
    GPIOIN = '0;
    cycles(SS + 3);
    ahb_read(32'(OFF_ISTAT), rd);
    check("t3_istat_fall", rd, 32'h1);

    // 4: input parity check
    ahb_write(32'(OFF_IE), 32'h0);
    ahb_write(32'(OFF_ITYPE), 32'h0);
    ahb_write(32'(OFF_DIR), 32'h0);
    GPIOIN = 17'h1_0001;
    cycles(SS + 2);
    ahb_write(32'(OFF_ISTAT), 32'h1FFFF);
    ahb_write(32'(OFF_PCTRL), 32'h2);
    cycles(3);
    ahb_read(32'(OFF_ISTAT), rd);
    check("t4_even_ok", 32'(rd[16]), 32'h0);
    GPIOIN = 17'h0_0001;
    cycles(SS + 2);
    ahb_read(32'(OFF_ISTAT), rd);
    check("t4_perr_set", 32'(rd[16]), 32'h1);
    check("t4_no_irq", 32'(GPIOIRQ), 32'h0);
    GPIOIN = 17'h1_0001;
    cycles(SS + 2);
    ahb_read(32'(OFF_ISTAT), rd);
    check("t4_sticky", 32'(rd[16]), 32'h1);
    ahb_write(32'(OFF_PCTRL), 32'h6);
    cycles(2);
    check("t4_irq_en", 32'(GPIOIRQ), 32'h1);
    ahb_write(32'(OFF_ISTAT), 32'h10000);
    cycles(2);
    ahb_read(32'(OFF_ISTAT), rd);
    check("t4_w1c", 32'(rd[16]), 32'h0);
    check("t4_irq_cleared", 32'(GPIOIRQ), 32'h0);

    // 5: set-wins-over-clear and back-to-back write/read
    ahb_write(32'(OFF_PCTRL), 32'h0);
    GPIOIN = '0;
    cycles(SS + 2);
    ahb_write(32'(OFF_ISTAT), 32'h1FFFF);
    GPIOIN = 17'h8;
    cycles(SS + 2);
    ahb_read(32'(OFF_ISTAT), rd);
    check("t5_bit3_set", rd, 32'h8);
    ahb_write(32'(OFF_ISTAT), 32'h8);
    ahb_read(32'(OFF_ISTAT), rd);
    check("t5_plain_clear", rd, 32'h0);
    GPIOIN = '0;
    cycles(SS + 2);
    ahb_write(32'(OFF_ISTAT), 32'h8);
    // Rise strobe reaches ISTAT on the same edge the W1C commits.
    GPIOIN = 17'h8;
    if (SS > 1) cycles(SS - 1);
    ahb_write(32'(OFF_ISTAT), 32'h8);
    ahb_read(32'(OFF_ISTAT), rd);
    check("t5_set_wins", rd, 32'h8);
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1; bus.HADDR = 32'(OFF_DIR);
    cycles(1);
    bus.HWRITE = 1'b0; bus.HWDATA = 32'h5A5A;
    cycles(1);
    bus_idle();
    check("t5_b2b_dir", bus.HRDATA, 32'h5A5A);
    cycles(1);

    // 6: reset mid-transfer, unmapped offset
    ahb_write(32'(OFF_ISTAT), 32'h1FFFF);
    ahb_write(32'(OFF_IE), 32'h8);
    GPIOIN = '0;
    cycles(SS + 2);
    GPIOIN = 17'h8;
    cycles(SS + 3);
    check("t6_irq_pre", 32'(GPIOIRQ), 32'h1);
    ahb_write(32'(OFF_DIR), 32'hFFFF);
    ahb_write(32'(OFF_DATA), 32'hBEEF);
    check("t6_out_pre", 32'(GPIOOUT), 32'h1_BEEF);
    GPIOIN = '0;
    cycles(SS + 2);
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1; bus.HADDR = 32'(OFF_DATA);
    cycles(1);
    bus_idle();
    bus.HWDATA = 32'h1234;
    #2 HRESETn = 1'b0;
    #1;
    check("t6_rst_out", 32'(GPIOOUT), 32'h0);
    check("t6_rst_irq", 32'(GPIOIRQ), 32'h0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    cycles(2);
    check("t6_drop_out", 32'(GPIOOUT), 32'h0);
    check("t6_drop_en", 32'(GPIOEN), 32'h0);
    for (int i = 1; i < 6; i++) begin
      ahb_read(32'(i * 4), rd);
      check($sformatf("t6_reg%0d", i), rd, 32'h0);
    end
    ahb_write(32'h40, 32'hFFFF_FFFF);
    ahb_read(32'h40, rd);
    check("t6_unmapped", rd, 32'h0);
    ahb_read(32'(OFF_DIR), rd);
    check("t6_unmapped_nochg", rd, 32'h0);
    check("t6_final_out", 32'(GPIOOUT), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
